mem_stage: RTL and testbench

Memory-access pipeline stage between EXE and WB. Latches each instruction from EXE, performs word and sub-word loads and stores over a request/acknowledge data-memory port, and registers results toward WB. It stalls the upstream pipeline while an access is outstanding and exposes its input-side destination register and ALU value as EXE's "start of MEM" forwarding source.

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EXE and WB: sub-word loads/stores over a req/ack port.
// Define MEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of masking them.
module mem_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        DMEM_Ack,
  input  logic [31:0] DMEM_RData,
  output logic        DMEM_Req,
  output logic        DMEM_Write,
  output logic [31:0] DMEM_Addr,
  output logic [31:0] DMEM_WData,
  output logic [3:0]  DMEM_ByteEn,
  output logic        STALL_OUT,
  output logic [4:0]  MemWriteReg,
  output logic [31:0] Mem_ALU_result,
  output logic        MemWriteValid,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WB_result1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        Align_Fault_OUT
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] load_q, load_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d, result_q, result_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwr_q, regwr_d;
  logic        fault_d;

  logic        is_mem;
  logic [1:0]  sz;      // 0 byte, 1 half, 2 word
  logic        uns;
  logic [1:0]  off;
  logic [3:0]  be_st;
  logic [31:0] wdata;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] lfmt;
  logic        fault_now;

  assign is_mem = MemRead1_IN | MemWrite1_IN;

  always_comb begin
    sz  = 2'd2;
    uns = 1'b0;
    case (ALU_Control1_IN)
      6'b100000: sz = 2'd0;
      6'b100100: begin sz = 2'd0; uns = 1'b1; end
      6'b100001: sz = 2'd1;
      6'b100101: begin sz = 2'd1; uns = 1'b1; end
      6'b101000: sz = 2'd0;
      6'b101001: sz = 2'd1;
      default:   sz = 2'd2;
    endcase
  end

  // Misaligned low address bits are masked off according to access size.
  always_comb begin
    case (sz)
      2'd0:    off = ALU_result1_IN[1:0];
      2'd1:    off = {ALU_result1_IN[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_q;
  assign fault_now = is_mem & (((sz == 2'd1) & ALU_result1_IN[0]) |
                               ((sz == 2'd2) & (ALU_result1_IN[1:0] != 2'b00)));
  assign Align_Fault_OUT = fault_q;
`else
  assign fault_now = 1'b0;
  assign Align_Fault_OUT = 1'b0;
`endif

  always_comb begin
    be_st = 4'b1111;
    wdata = MemWriteData1_IN;
    case (sz)
      2'd0: begin
        be_st = 4'b1000 >> off;
        wdata = {4{MemWriteData1_IN[7:0]}};
      end
      2'd1: begin
        be_st = off[1] ? 4'b0011 : 4'b1100;
        wdata = {2{MemWriteData1_IN[15:0]}};
      end
      default: ;
    endcase
  end

  // Big-endian lanes: offset 0 is bits 31:24.
  always_comb begin
    case (off)
      2'd0:    lbyte = DMEM_RData[31:24];
      2'd1:    lbyte = DMEM_RData[23:16];
      2'd2:    lbyte = DMEM_RData[15:8];
      default: lbyte = DMEM_RData[7:0];
    endcase
    lhalf = off[1] ? DMEM_RData[15:0] : DMEM_RData[31:16];
    case (sz)
      2'd0:    lfmt = uns ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
      2'd1:    lfmt = uns ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
      default: lfmt = DMEM_RData;
    endcase
  end

  always_comb begin
    DMEM_Req    = (state_q == REQ);
    DMEM_Write  = DMEM_Req & MemWrite1_IN;
    DMEM_Addr   = DMEM_Req ? {ALU_result1_IN[31:2], 2'b00} : '0;
    DMEM_ByteEn = DMEM_Req ? (MemWrite1_IN ? be_st : 4'b1111) : '0;
    DMEM_WData  = DMEM_Write ? wdata : '0;
    STALL_OUT   = RESET & (((state_q == IDLE) & is_mem & ~fault_now) | (state_q == REQ));
  end

  assign MemWriteReg    = WriteRegister1_IN;
  assign Mem_ALU_result = ALU_result1_IN;
  assign MemWriteValid  = RegWrite1_IN & ~MemRead1_IN;

  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    fault_d  = 1'b0;
    instr_d  = '0;
    pc_d     = '0;
    result_d = '0;
    wreg_d   = '0;
    regwr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (fault_now) fault_d = 1'b1;
          else           state_d = REQ;
        end else begin
          instr_d  = Instr1_IN;
          pc_d     = Instr1_PC_IN;
          result_d = ALU_result1_IN;
          wreg_d   = WriteRegister1_IN;
          regwr_d  = RegWrite1_IN;
        end
      end
      REQ: begin
        if (DMEM_Ack) begin
          load_d  = lfmt;
          state_d = DONE;
        end
      end
      DONE: begin
        instr_d  = Instr1_IN;
        pc_d     = Instr1_PC_IN;
        result_d = MemRead1_IN ? load_q : ALU_result1_IN;
        wreg_d   = WriteRegister1_IN;
        regwr_d  = RegWrite1_IN;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      load_q   <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      result_q <= '0;
      wreg_q   <= '0;
      regwr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      wreg_q   <= wreg_d;
      regwr_q  <= regwr_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  logic unused_fault;
  assign unused_fault = fault_d;
`endif

  assign Instr1_OUT         = instr_q;
  assign Instr1_PC_OUT      = pc_q;
  assign WB_result1_OUT     = result_q;
  assign WriteRegister1_OUT = wreg_q;
  assign RegWrite1_OUT      = regwr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then randomized instruction stream.
module tb_mem_stage;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN, DMEM_RData;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN, DMEM_Ack;
  logic [5:0]  ALU_Control1_IN;
  logic        DMEM_Req, DMEM_Write, STALL_OUT, MemWriteValid, RegWrite1_OUT, Align_Fault_OUT;
  logic [31:0] DMEM_Addr, DMEM_WData, Mem_ALU_result, Instr1_OUT, Instr1_PC_OUT, WB_result1_OUT;
  logic [3:0]  DMEM_ByteEn;
  logic [4:0]  MemWriteReg, WriteRegister1_OUT;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .DMEM_Ack(DMEM_Ack), .DMEM_RData(DMEM_RData),
    .DMEM_Req(DMEM_Req), .DMEM_Write(DMEM_Write), .DMEM_Addr(DMEM_Addr),
    .DMEM_WData(DMEM_WData), .DMEM_ByteEn(DMEM_ByteEn), .STALL_OUT(STALL_OUT),
    .MemWriteReg(MemWriteReg), .Mem_ALU_result(Mem_ALU_result), .MemWriteValid(MemWriteValid),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .WB_result1_OUT(WB_result1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .Align_Fault_OUT(Align_Fault_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic [31:0] ins, pc, res,
                          input logic [4:0] wr, input logic rw, input logic flt);
    check_val({tag, ".instr"},  Instr1_OUT, ins);
    check_val({tag, ".pc"},     Instr1_PC_OUT, pc);
    check_val({tag, ".result"}, WB_result1_OUT, res);
    check_val({tag, ".wreg"},   {27'd0, WriteRegister1_OUT}, {27'd0, wr});
    check_val({tag, ".regwr"},  {31'd0, RegWrite1_OUT}, {31'd0, rw});
    check_val({tag, ".fault"},  {31'd0, Align_Fault_OUT}, {31'd0, flt});
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Presents one instruction and follows it to completion; entered and left at posedge+1.
  task automatic run_instr(input string tag, input logic [5:0] ctl, input logic rd, wr, rw,
                           input logic [31:0] addr, wd, rdata, input logic [4:0] wreg,
                           input int unsigned waits);
    logic [31:0] ins, pc, exp_wdata, exp_load;
    logic [3:0]  exp_be;
    logic [1:0]  o;
    logic [7:0]  b;
    logic [15:0] h;
    logic        is_byte, is_half, is_uns, flt;
    ins = $urandom; pc = $urandom;
    Instr1_IN = ins; Instr1_PC_IN = pc; ALU_result1_IN = addr; MemWriteData1_IN = wd;
    WriteRegister1_IN = wreg; RegWrite1_IN = rw; MemRead1_IN = rd; MemWrite1_IN = wr;
    ALU_Control1_IN = ctl; DMEM_Ack = 1'($urandom_range(0, 1)); DMEM_RData = $urandom;
    is_byte = (ctl == 6'b100000) || (ctl == 6'b100100) || (ctl == 6'b101000);
    is_half = (ctl == 6'b100001) || (ctl == 6'b100101) || (ctl == 6'b101001);
    is_uns  = (ctl == 6'b100100) || (ctl == 6'b100101);
    flt = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((rd || wr) && ((is_half && addr[0]) || (!is_half && !is_byte && addr[1:0] != 2'b00)))
      flt = 1'b1;
`endif
    #1;
    check_val({tag, ".stall_idle"}, {31'd0, STALL_OUT}, {31'd0, (rd || wr) && !flt});
    check_val({tag, ".req_idle"},   {31'd0, DMEM_Req}, 32'd0);
    check_val({tag, ".fwd_reg"},    {27'd0, MemWriteReg}, {27'd0, wreg});
    check_val({tag, ".fwd_alu"},    Mem_ALU_result, addr);
    check_val({tag, ".fwd_valid"},  {31'd0, MemWriteValid}, {31'd0, rw && !rd});
    tick();
    if (!(rd || wr)) begin
      check_wb({tag, ".wb"}, ins, pc, addr, wreg, rw, 1'b0);
      return;
    end
    check_wb({tag, ".bubble0"}, '0, '0, '0, '0, 1'b0, flt);
    if (flt) return;

    o = addr[1:0];
    exp_be = 4'b1111; exp_wdata = wd;
    if (wr && is_byte) begin exp_be = 4'b1000 >> o; exp_wdata = {4{wd[7:0]}}; end
    if (wr && is_half) begin exp_be = addr[1] ? 4'b0011 : 4'b1100; exp_wdata = {2{wd[15:0]}}; end
    b = 8'((rdata >> (8 * (3 - int'(o)))) & 32'hFF);
    h = addr[1] ? rdata[15:0] : rdata[31:16];
    if (is_byte)      exp_load = is_uns ? {24'd0, b} : 32'($signed(b));
    else if (is_half) exp_load = is_uns ? {16'd0, h} : 32'($signed(h));
    else              exp_load = rdata;

    for (int unsigned k = 0; k <= waits; k++) begin
      DMEM_Ack = (k == waits);
      DMEM_RData = (k == waits) ? rdata : $urandom;
      #1;
      check_val({tag, ".req"},   {31'd0, DMEM_Req}, 32'd1);
      check_val({tag, ".stall"}, {31'd0, STALL_OUT}, 32'd1);
      check_val({tag, ".write"}, {31'd0, DMEM_Write}, {31'd0, wr});
      check_val({tag, ".addr"},  DMEM_Addr, {addr[31:2], 2'b00});
      check_val({tag, ".be"},    {28'd0, DMEM_ByteEn}, {28'd0, exp_be});
      if (wr) check_val({tag, ".wdata"}, DMEM_WData, exp_wdata);
      tick();
      check_wb({tag, ".bubble"}, '0, '0, '0, '0, 1'b0, 1'b0);
    end
    DMEM_Ack = 1'($urandom_range(0, 1)); DMEM_RData = $urandom;
    #1;
    check_val({tag, ".stall_done"}, {31'd0, STALL_OUT}, 32'd0);
    check_val({tag, ".req_done"},   {31'd0, DMEM_Req}, 32'd0);
    tick();
    check_wb({tag, ".wb"}, ins, pc, rd ? exp_load : addr, wreg, rw, 1'b0);
  endtask

  logic [5:0] ops [8];

  initial begin
    ops = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
            6'b101000, 6'b101001, 6'b101011};
    RESET = 1'b0; DMEM_Ack = 1'b0; DMEM_RData = '0;
    Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
    WriteRegister1_IN = '0; RegWrite1_IN = 1'b0; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
    ALU_Control1_IN = '0;
    repeat (3) tick();
    check_wb("reset", '0, '0, '0, '0, 1'b0, 1'b0);
    check_val("reset.req",   {31'd0, DMEM_Req}, 32'd0);
    check_val("reset.stall", {31'd0, STALL_OUT}, 32'd0);
    RESET = 1'b1;

    run_instr("add",  6'b000000, 1'b0, 1'b0, 1'b1, 32'h5,   32'h0,      32'h0,        5'd3, 0);
    run_instr("lw",   6'b100011, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,      32'hDEADBEEF, 5'd4, 0);
    run_instr("lb",   6'b100000, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0,      32'h000000F0, 5'd5, 3);
    run_instr("lbu",  6'b100100, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0,      32'h000000F0, 5'd6, 3);
    run_instr("sh",   6'b101001, 1'b0, 1'b1, 1'b0, 32'h202, 32'h0000ABCD, 32'h0,      5'd0, 1);
    run_instr("lh0",  6'b100001, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0,      32'h8001_7FFE, 5'd7, 0);
    run_instr("lhu2", 6'b100101, 1'b1, 1'b0, 1'b1, 32'h202, 32'h0,      32'h8001_FFFE, 5'd8, 0);
    run_instr("sb1",  6'b101000, 1'b0, 1'b1, 1'b1, 32'h301, 32'h12345678, 32'h0,      5'd9, 2);
`ifdef MEM_ALIGN_CHECK_EN
    run_instr("lw_mis", 6'b100011, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 32'h0, 5'd10, 0);
`endif
    run_instr("add2", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 32'h0, 5'd11, 0);

    // SW abandoned by reset while the request is outstanding.
    Instr1_IN = 32'hA; Instr1_PC_IN = 32'hB; ALU_result1_IN = 32'h400; MemWriteData1_IN = 32'h55;
    WriteRegister1_IN = 5'd0; RegWrite1_IN = 1'b0; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b1;
    ALU_Control1_IN = 6'b101011; DMEM_Ack = 1'b0;
    tick();
    #1;
    check_val("rst_sw.req_before", {31'd0, DMEM_Req}, 32'd1);
    RESET = 1'b0;
    #1;
    check_val("rst_sw.req",   {31'd0, DMEM_Req}, 32'd0);
    check_val("rst_sw.stall", {31'd0, STALL_OUT}, 32'd0);
    check_val("rst_sw.addr",  DMEM_Addr, 32'd0);
    check_val("rst_sw.be",    {28'd0, DMEM_ByteEn}, 32'd0);
    check_wb("rst_sw", '0, '0, '0, '0, 1'b0, 1'b0);
    DMEM_Ack = 1'b1;
    tick();
    DMEM_Ack = 1'b0; RESET = 1'b1;
    run_instr("add_after_rst", 6'b000000, 1'b0, 1'b0, 1'b1, 32'h9, 32'h0, 32'h0, 5'd12, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [5:0]  c;
      logic        r, w, rwv;
      int unsigned sel;
      a = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        c = 6'($urandom); r = 1'b0; w = 1'b0; rwv = 1'($urandom_range(0, 1));
      end else begin
        c = ops[$urandom_range(0, 7)];
        r = (c[3] == 1'b0); w = !r;
        rwv = r ? 1'b1 : 1'($urandom_range(0, 1));
      end
      run_instr("rand", c, r, w, rwv, a, $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
